neural_pio_sequencer: RTL and testbench

//  Command sequencer between Nios software and the neural datapath, driven by the 32-bit PIO pair.

---
 rtl/neural_pio_pkg.sv | 50 +++++
 rtl/neural_layer_timer.sv | 37 +++
 rtl/neural_pio_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_neural_pio_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/neural_pio_pkg.sv
// Shared definitions for the Nios PIO command sequencer: opcodes, status
// codes, command/response field positions and FSM state encoding.
package neural_pio_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_WR_WEIGHT = 3'd1,
    OP_WR_INPUT  = 3'd2,
    OP_RUN       = 3'd3,
    OP_RD_OUTPUT = 3'd4,
    OP_CLEAR     = 3'd5,
    OP_BAD6      = 3'd6,
    OP_BAD7      = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    STAT_OK       = 2'd0,
    STAT_BAD_OP   = 2'd1,
    STAT_BAD_ADDR = 2'd2,
    STAT_TIMEOUT  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_READ_WAIT,
    S_RUN_START,
    S_RUN_WAIT,
    S_RESPOND
  } state_e;

  // Command word fields
  localparam int unsigned CMD_TOG_BIT = 31;
  localparam int unsigned CMD_OP_LO   = 28;
  localparam int unsigned CMD_ADDR_LO = 16;
  localparam int unsigned CMD_DATA_LO = 0;

  // Response word fields
  localparam int unsigned RSP_BUSY_BIT = 30;

  // Assemble a response word: ack, busy, status, addr echo, data
  function automatic logic [31:0] pack_rsp(input logic ack, input logic busy,
                                           input status_e st,
                                           input logic [11:0] addr,
                                           input logic [15:0] data);
    return {ack, busy, st, addr, data};
  endfunction

endpackage

// File: rtl/neural_layer_timer.sv
// Loadable 16-bit saturating cycle counter; expired flags when LIMIT reached.
module neural_layer_timer #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT_W = 16'(LIMIT);

  logic [15:0] cnt_q, cnt_d;

  // Next count: load clears, enable increments until saturation
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q >= LIMIT_W);

endmodule

// File: rtl/neural_pio_sequencer.sv
// Command sequencer between the Nios PIO mailbox and the neural datapath.
module neural_pio_sequencer
  import neural_pio_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_LAYERS  = 8,
  parameter int unsigned LAYER_W     = 3,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [31:0]        to_hw_port,
  output logic [31:0]        to_sw_port,
  input  logic               abort_req,
  output logic               wmem_we,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  omem_rdata,
  output logic               mac_start,
  output logic [LAYER_W-1:0] mac_layer,
  input  logic               mac_done
);

  localparam logic [LAYER_W:0]  MAX_N     = (LAYER_W+1)'(MAX_LAYERS);
  localparam logic [LAYER_W:0]  ONE_N     = (LAYER_W+1)'(1);
  localparam logic [DATA_W-1:0] ABORT_TAG = DATA_W'(16'hAB00);

  state_e              state_q, state_d;
  logic                last_tog_q, last_tog_d;
  logic [31:0]         cmd_q, cmd_d;
  status_e             rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rd_phase_q, rd_phase_d;
  logic [LAYER_W:0]    k_q, k_d;
  logic [31:0]         to_sw_q, to_sw_d;
  logic                wmem_we_q, wmem_we_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mac_start_q, mac_start_d;
  logic [LAYER_W-1:0]  mac_layer_q, mac_layer_d;

  logic                timer_load, timer_en, timer_expired;

  opcode_e             cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_data;
  logic [LAYER_W:0]    run_n;
  logic                run_n_ok;

  assign cmd_op   = opcode_e'(cmd_q[CMD_OP_LO +: 3]);
  assign cmd_addr = cmd_q[CMD_ADDR_LO +: ADDR_W];
  assign cmd_data = cmd_q[CMD_DATA_LO +: DATA_W];
  assign run_n    = cmd_q[CMD_ADDR_LO +: LAYER_W+1];
  assign run_n_ok = (run_n != '0) && (run_n <= MAX_N);
  assign timer_en = (state_q == S_RUN_START) || (state_q == S_RUN_WAIT);

  neural_layer_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // FSM next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    last_tog_d   = last_tog_q;
    cmd_d        = cmd_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    rd_phase_d   = rd_phase_q;
    k_d          = k_q;
    to_sw_d      = to_sw_q;
    wmem_we_d    = 1'b0;
    imem_we_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mac_start_d  = 1'b0;
    mac_layer_d  = mac_layer_q;
    timer_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (to_hw_port[CMD_TOG_BIT] != last_tog_q) begin
          cmd_d                 = to_hw_port;
          last_tog_d            = to_hw_port[CMD_TOG_BIT];
          to_sw_d[RSP_BUSY_BIT] = 1'b1;
          state_d               = S_DECODE;
        end
      end

      S_DECODE: begin
        mem_addr_d   = cmd_addr;
        mem_wdata_d  = cmd_data;
        rsp_status_d = STAT_OK;
        rsp_data_d   = cmd_data;
        state_d      = S_EXEC;
        case (cmd_op)
          OP_WR_WEIGHT: wmem_we_d = 1'b1;
          OP_WR_INPUT:  imem_we_d = 1'b1;
          OP_RUN: begin
            if (run_n_ok) begin
              k_d         = '0;
              mac_layer_d = '0;
              mac_start_d = 1'b1;
              timer_load  = 1'b1;
              state_d     = S_RUN_START;
            end else begin
              rsp_status_d = STAT_BAD_ADDR;
              rsp_data_d   = '0;
            end
          end
          OP_RD_OUTPUT: begin
            rd_phase_d = 1'b0;
            state_d    = S_READ_WAIT;
          end
          OP_CLEAR: rsp_data_d = '0;
          OP_BAD6, OP_BAD7: begin
            rsp_status_d = STAT_BAD_OP;
            rsp_data_d   = '0;
          end
          default: ;
        endcase
      end

      S_EXEC: state_d = S_RESPOND;

      // First cycle lets the memory see mem_addr; second captures its data
      S_READ_WAIT: begin
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          rsp_data_d = omem_rdata;
          state_d    = S_RESPOND;
        end
      end

      S_RUN_START: begin
        if (abort_req) begin
          rsp_status_d = STAT_TIMEOUT;
          rsp_data_d   = ABORT_TAG | DATA_W'(k_q);
          state_d      = S_RESPOND;
        end else begin
          state_d = S_RUN_WAIT;
        end
      end

      // Abort outranks mac_done, which outranks the timeout
      S_RUN_WAIT: begin
        if (abort_req) begin
          rsp_status_d = STAT_TIMEOUT;
          rsp_data_d   = ABORT_TAG | DATA_W'(k_q);
          state_d      = S_RESPOND;
        end else if (mac_done) begin
          if (k_q == (run_n - ONE_N)) begin
            rsp_status_d = STAT_OK;
            rsp_data_d   = DATA_W'(run_n);
            state_d      = S_RESPOND;
          end else begin
            k_d         = k_q + ONE_N;
            mac_layer_d = k_d[LAYER_W-1:0];
            mac_start_d = 1'b1;
            timer_load  = 1'b1;
            state_d     = S_RUN_START;
          end
        end else if (timer_expired) begin
          rsp_status_d = STAT_TIMEOUT;
          rsp_data_d   = DATA_W'(k_q);
          state_d      = S_RESPOND;
        end
      end

      S_RESPOND: begin
        to_sw_d = pack_rsp(cmd_q[CMD_TOG_BIT], 1'b0, rsp_status_q,
                           cmd_addr, rsp_data_q);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset re-samples the software toggle
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= S_IDLE;
      last_tog_q   <= to_hw_port[CMD_TOG_BIT];
      cmd_q        <= '0;
      rsp_status_q <= STAT_OK;
      rsp_data_q   <= '0;
      rd_phase_q   <= 1'b0;
      k_q          <= '0;
      to_sw_q      <= '0;
      wmem_we_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mac_start_q  <= 1'b0;
      mac_layer_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_tog_q   <= last_tog_d;
      cmd_q        <= cmd_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      rd_phase_q   <= rd_phase_d;
      k_q          <= k_d;
      to_sw_q      <= to_sw_d;
      wmem_we_q    <= wmem_we_d;
      imem_we_q    <= imem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mac_start_q  <= mac_start_d;
      mac_layer_q  <= mac_layer_d;
    end
  end

  assign to_sw_port = to_sw_q;
  assign wmem_we    = wmem_we_q;
  assign imem_we    = imem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mac_start  = mac_start_q;
  assign mac_layer  = mac_layer_q;

endmodule

// File: tb/tb_neural_pio_sequencer.sv
// Directed bench for neural_pio_sequencer with a small datapath/memory model.
module tb_neural_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [31:0] to_hw_port;
  logic [31:0] to_sw_port;
  logic        abort_req;
  logic        wmem_we, imem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] omem_rdata;
  logic        mac_start;
  logic [2:0]  mac_layer;
  logic        mac_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        tog = 1'b0;

  // Datapath / memory model state
  logic        auto_done = 1'b0;
  int          cd = 0;
  int          wmem_cnt = 0;
  logic [11:0] prev_addr = '0;
  int          layer_log[$];

  neural_pio_sequencer #(
    .ADDR_W(12), .DATA_W(16), .MAX_LAYERS(8), .LAYER_W(3), .TIMEOUT_CYC(65535)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .to_hw_port  (to_hw_port),
    .to_sw_port  (to_sw_port),
    .abort_req   (abort_req),
    .wmem_we     (wmem_we),
    .imem_we     (imem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .omem_rdata  (omem_rdata),
    .mac_start   (mac_start),
    .mac_layer   (mac_layer),
    .mac_done    (mac_done)
  );

  always #5 clk = ~clk;

  // Model: mac_done 10 cycles after each start; output memory with 1-cycle latency
  always @(negedge clk) begin
    if (reset_reset) begin
      cd = 0;
      mac_done = 1'b0;
    end else if (mac_start) begin
      layer_log.push_back(int'(mac_layer));
      mac_done = 1'b0;
      if (auto_done) cd = 10;
    end else if (cd > 0) begin
      cd--;
      mac_done = (cd == 0);
    end else begin
      mac_done = 1'b0;
    end
    if (wmem_we) wmem_cnt++;
    omem_rdata = (prev_addr == 12'h005) ? 16'h1234 : 16'hDEAD;
    prev_addr  = mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [15:0] data);
    @(negedge clk);
    tog = ~tog;
    to_hw_port = {tog, op, addr, data};
  endtask

  // Short command: checks strobes each edge, no early ack, full word at lat
  task automatic run_simple(input string tag, input logic [2:0] op, input logic [11:0] addr,
                            input logic [15:0] data, input int lat,
                            input logic [1:0] st, input logic [15:0] d);
    logic [31:0] exp;
    logic        pre;
    pre = to_sw_port[31];
    issue(op, addr, data);
    exp = {tog, 1'b0, st, addr, d};
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk); #1;
      chk({tag, "_wmem"}, 32'(wmem_we), 32'((op == 3'd1) && (e == 2)));
      chk({tag, "_imem"}, 32'(imem_we), 32'((op == 3'd2) && (e == 2)));
      if (e == 2 && (op == 3'd1 || op == 3'd2)) begin
        chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(data));
      end
      if (e < lat) chk({tag, "_early_ack"}, 32'(to_sw_port[31]), 32'(pre));
      else         chk(tag, to_sw_port, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output logic got, output logic busy_seen);
    got = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < limit && !got; c++) begin
      @(posedge clk); #1;
      if (to_sw_port[30]) busy_seen = 1'b1;
      if (to_sw_port[31] == tog) got = 1'b1;
    end
  endtask

  initial begin
    logic got, busy_seen;
    int   starts_before;
    logic [31:0] hold;

    reset_reset = 1'b1;
    to_hw_port  = '0;
    abort_req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_to_sw", to_sw_port, 32'h0);
    chk("rst_ctrl", {26'b0, wmem_we, imem_we, mac_start, mac_layer}, 32'h0);
    chk("rst_addr_wdata", {4'b0, mem_addr, mem_wdata}, 32'h0);
    @(negedge clk);
    reset_reset = 1'b0;

    // Writes, NOP, CLEAR
    run_simple("wr_weight", 3'd1, 12'h012, 16'hBEEF, 4, 2'd0, 16'hBEEF);
    chk("wr_weight_word", to_sw_port, 32'h8012_BEEF);
    run_simple("wr_input", 3'd2, 12'h3C0, 16'h0F0F, 4, 2'd0, 16'h0F0F);
    run_simple("nop", 3'd0, 12'h001, 16'h7777, 4, 2'd0, 16'h7777);
    run_simple("clear", 3'd5, 12'h0FF, 16'h9999, 4, 2'd0, 16'h0000);

    // RUN N=3 with datapath answering
    layer_log.delete();
    auto_done = 1'b1;
    issue(3'd3, 12'h003, 16'h0000);
    wait_ack(400, got, busy_seen);
    chk("run3_ack_in_time", 32'(got), 32'd1);
    chk("run3_busy_seen", 32'(busy_seen), 32'd1);
    chk("run3_nstarts", layer_log.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("run3_layer", (i < layer_log.size()) ? layer_log[i] : -1, i);
    chk("run3_rsp", to_sw_port, {tog, 1'b0, 2'd0, 12'h003, 16'h0003});
    auto_done = 1'b0;

    // Bad layer counts, bad opcodes
    starts_before = layer_log.size();
    run_simple("run_n0", 3'd3, 12'h000, 16'h0000, 4, 2'd2, 16'h0000);
    run_simple("run_n9", 3'd3, 12'h009, 16'h0000, 4, 2'd2, 16'h0000);
    chk("run_bad_no_start", layer_log.size(), starts_before);
    run_simple("op7", 3'd7, 12'h0AA, 16'h1111, 4, 2'd1, 16'h0000);
    run_simple("op6", 3'd6, 12'h0BB, 16'h2222, 4, 2'd1, 16'h0000);

    // Toggle unchanged: must be ignored
    hold = to_sw_port;
    starts_before = wmem_cnt;
    @(negedge clk);
    to_hw_port = {tog, 3'd1, 12'h055, 16'h3333};
    repeat (8) @(posedge clk);
    #1;
    chk("same_tog_rsp", to_sw_port, hold);
    chk("same_tog_no_write", wmem_cnt, starts_before);

    // Read output memory
    run_simple("rd_output", 3'd4, 12'h005, 16'h0000, 5, 2'd0, 16'h1234);

    // Timeout: datapath never answers
    layer_log.delete();
    issue(3'd3, 12'h002, 16'h0000);
    wait_ack(70000, got, busy_seen);
    chk("timeout_ack_in_time", 32'(got), 32'd1);
    chk("timeout_rsp", to_sw_port, {tog, 1'b0, 2'd3, 12'h002, 16'h0000});
    chk("timeout_nstarts", layer_log.size(), 32'd1);

    // Abort during layer 1
    auto_done = 1'b1;
    issue(3'd3, 12'h002, 16'h0000);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (mac_start && mac_layer == 3'd1) got = 1'b1;
    end
    chk("abort_reached_l1", 32'(got), 32'd1);
    abort_req = 1'b1;
    wait_ack(20, got, busy_seen);
    chk("abort_ack_in_time", 32'(got), 32'd1);
    chk("abort_rsp", to_sw_port, {tog, 1'b0, 2'd3, 12'h002, 16'hAB01});
    abort_req = 1'b0;
    repeat (15) @(posedge clk);
    auto_done = 1'b0;
    run_simple("after_abort_nop", 3'd0, 12'h00C, 16'h4242, 4, 2'd0, 16'h4242);

    // Reset asserted mid-run
    auto_done = 1'b1;
    issue(3'd3, 12'h003, 16'h0000);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (mac_start && mac_layer == 3'd1) got = 1'b1;
    end
    chk("midrst_reached_l1", 32'(got), 32'd1);
    @(negedge clk);
    reset_reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_to_sw", to_sw_port, 32'h0);
    chk("midrst_ctrl", {26'b0, wmem_we, imem_we, mac_start, mac_layer}, 32'h0);
    chk("midrst_addr_wdata", {4'b0, mem_addr, mem_wdata}, 32'h0);
    @(negedge clk);
    reset_reset = 1'b0;
    auto_done = 1'b0;
    run_simple("post_rst_wr", 3'd2, 12'h0AB, 16'h5A5A, 4, 2'd0, 16'h5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
